// File: rtl/recovery_pkg.sv
// recovery_pkg: shared state encoding and default constants for recovery_sequencer (RECOVERY_WATCHDOG_EN-aware build)
package recovery_pkg;
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    FLUSH   = 3'd2,
    RESTORE = 3'd3,
    HALT    = 3'd4
  } state_e;
  localparam logic [31:0] DEF_RESET_PC      = 32'h0000_0000;
  localparam int          DEF_MAX_RETRY     = 3;
  localparam int          DEF_RETRY_WINDOW  = 64;
  localparam int          DEF_DRAIN_TIMEOUT = 16;
endpackage

// File: rtl/drain_watchdog.sv
// drain_watchdog: counts DRAIN cycles and flags when TIMEOUT cycles have elapsed (used only with RECOVERY_WATCHDOG_EN)
module drain_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear on entry, count while draining, saturate at the limit
  always_comb cnt_d = start ? '0 : (active && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  // the cycle holding TIMEOUT-1 is the last allowed drain cycle
  assign expired = active && (cnt_q >= CW'(TIMEOUT - 1));
endmodule

// File: rtl/recovery_sequencer.sv
// recovery_sequencer: fault-recovery FSM (freeze/drain/flush/restore, bounded retries, sticky halt); drain watchdog under RECOVERY_WATCHDOG_EN
module recovery_sequencer
  import recovery_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEF_RESET_PC,
  parameter int          MAX_RETRY     = DEF_MAX_RETRY,
  parameter int          RETRY_WINDOW  = DEF_RETRY_WINDOW,
  parameter int          DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               fault_valid,
  input  logic                               fault_critical,
  input  logic                               commit_valid,
  input  logic [31:0]                        commit_pc,
  input  logic                               pipe_empty,
  output logic                               freeze,
  output logic                               flush,
  output logic                               pc_restore_valid,
  output logic [31:0]                        pc_restore,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_count,
  output logic                               halted
);
  localparam int RCW = $clog2(MAX_RETRY + 1);
  localparam int CCW = $clog2(RETRY_WINDOW + 1);
  state_e         state_q, state_d;
  logic [31:0]    ckpt_q, ckpt_d;
  logic [CCW-1:0] clean_q, clean_d;
  logic [RCW-1:0] retry_q, retry_d;
  logic           crit, wd_expired;
  assign crit = fault_valid && fault_critical;
`ifdef RECOVERY_WATCHDOG_EN
  drain_watchdog #(.TIMEOUT(DRAIN_TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .start   (state_q != DRAIN && state_d == DRAIN),
    .active  (state_q == DRAIN),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0 && (DRAIN_TIMEOUT > 0);
`endif
  // next-state, checkpoint capture, clean-window and retry bookkeeping
  always_comb begin
    state_d = state_q;
    ckpt_d  = ckpt_q;
    clean_d = clean_q;
    retry_d = retry_q;
    case (state_q)
      RUN: begin
        if (fault_valid) begin
          clean_d = '0;
          state_d = (fault_critical || retry_q == RCW'(MAX_RETRY)) ? HALT : DRAIN;
        end else if (commit_valid) begin
          ckpt_d  = commit_pc;
          clean_d = (clean_q == CCW'(RETRY_WINDOW)) ? clean_q : clean_q + 1'b1;
          retry_d = (clean_d == CCW'(RETRY_WINDOW)) ? '0 : retry_q;
        end
      end
      DRAIN:   state_d = (crit || (wd_expired && !pipe_empty)) ? HALT : pipe_empty ? FLUSH : DRAIN;
      FLUSH:   state_d = crit ? HALT : RESTORE;
      RESTORE: begin
        retry_d = (retry_q == RCW'(MAX_RETRY)) ? retry_q : retry_q + 1'b1;
        state_d = crit ? HALT : RUN;
      end
      default: state_d = HALT;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    state_q <= reset ? RUN : state_d;
    ckpt_q  <= reset ? RESET_PC : ckpt_d;
    clean_q <= reset ? '0 : clean_d;
    retry_q <= reset ? '0 : retry_d;
  end
  assign freeze           = state_q != RUN;
  assign flush            = state_q == FLUSH;
  assign pc_restore_valid = state_q == RESTORE;
  assign halted           = state_q == HALT;
  assign pc_restore       = ckpt_q;
  assign retry_count      = retry_q;
endmodule

// File: tb/tb_recovery_sequencer.sv
// tb_recovery_sequencer: directed scenarios plus randomized traffic against a behavioural recovery model (honours RECOVERY_WATCHDOG_EN)
module tb_recovery_sequencer;
  localparam int MR = 3, WIN = 64, TO = 16;
`ifdef RECOVERY_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, fault_valid, fault_critical, commit_valid, pipe_empty;
  logic [31:0] commit_pc;
  logic freeze, flush, pc_restore_valid, halted;
  logic [31:0] pc_restore;
  logic [1:0] retry_count;
  int checks = 0, passed = 0;
  bit m_halt;
  int m_phase, m_retry, m_clean, m_dwell;
  logic [31:0] m_ckpt;

  recovery_sequencer dut (
    .clk(clk), .reset(reset), .fault_valid(fault_valid), .fault_critical(fault_critical),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .pipe_empty(pipe_empty),
    .freeze(freeze), .flush(flush), .pc_restore_valid(pc_restore_valid),
    .pc_restore(pc_restore), .retry_count(retry_count), .halted(halted)
  );

  always #5 clk = ~clk;

  // phase: 0 running, 1 waiting for an empty pipe, 2 flushing, 3 restoring
  task automatic model(input bit r, fv, fc, cv, input logic [31:0] pc, input bit pe);
    if (r) begin
      m_halt = 0; m_phase = 0; m_retry = 0; m_clean = 0; m_dwell = 0; m_ckpt = 32'h0;
    end else if (!m_halt) begin
      if (m_phase == 0) begin
        if (fv) begin
          m_clean = 0;
          if (fc || m_retry == MR) m_halt = 1;
          else begin m_phase = 1; m_dwell = 0; end
        end else if (cv) begin
          m_ckpt = pc;
          if (m_clean < WIN) m_clean++;
          if (m_clean == WIN) m_retry = 0;
        end
      end else if (m_phase == 1) begin
        m_dwell++;
        if (fv && fc) m_halt = 1;
        else if (pe) m_phase = 2;
        else if (WD && m_dwell >= TO) m_halt = 1;
      end else if (m_phase == 2) begin
        if (fv && fc) m_halt = 1; else m_phase = 3;
      end else begin
        if (m_retry < MR) m_retry++;
        if (fv && fc) m_halt = 1; else m_phase = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, fv, fc, cv, input logic [31:0] pc, input bit pe);
    reset = r; fault_valid = fv; fault_critical = fc; commit_valid = cv; commit_pc = pc; pipe_empty = pe;
    @(posedge clk);
    model(r, fv, fc, cv, pc, pe);
    #1;
  endtask

  function automatic logic [37:0] got();
    return {freeze, flush, pc_restore_valid, halted, retry_count, pc_restore};
  endfunction

  function automatic logic [37:0] want();
    return {m_halt || m_phase != 0, !m_halt && m_phase == 2, !m_halt && m_phase == 3, m_halt, 2'(m_retry), m_ckpt};
  endfunction

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 32'hFFFF_FFFC, 0);
    checks++;
    if ({freeze, flush, pc_restore_valid, halted, retry_count} !== 6'b0 || pc_restore !== 32'h0)
      $display("FAIL reset_values got=%h want=%h", got(), 38'h0);
    else passed++;
  endtask

  task automatic test_single_recovery();
    int nf = 0, nfl = 0, npv = 0;
    logic [31:0] rpc = 32'hx;
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h100, 1);
    cyc(0, 0, 0, 1, 32'h104, 1);
    cyc(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      nf += int'(freeze); nfl += int'(flush); npv += int'(pc_restore_valid);
      if (pc_restore_valid) rpc = pc_restore;
      checks++;
      if (got() !== want()) $display("FAIL single_cycle%0d got=%h want=%h", i, got(), want()); else passed++;
      cyc(0, 0, 0, 0, 0, 1);
    end
    checks++;
    if (nf != 3 || nfl != 1 || npv != 1) $display("FAIL single_pulses got freeze=%0d flush=%0d restore=%0d want 3/1/1", nf, nfl, npv); else passed++;
    checks++;
    if (rpc !== 32'h104 || retry_count !== 2'd1) $display("FAIL single_restore got pc=%h retry=%0d want pc=104 retry=1", rpc, retry_count); else passed++;
  endtask

  task automatic test_escalation();
    cyc(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 1, 32'h40 * k, 1);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got() !== want()) $display("FAIL escalate_f%0d_c%0d got=%h want=%h", k, i, got(), want()); else passed++;
        cyc(0, 0, 0, 0, 0, 1);
      end
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (!(halted === 1'b1 && freeze === 1'b1 && flush === 1'b0 && pc_restore_valid === 1'b0))
        $display("FAIL escalate_sticky%0d got halted=%b freeze=%b want 1/1", i, halted, freeze);
      else passed++;
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
    end
    cyc(1, 0, 0, 0, 0, 1);
    checks++;
    if (halted !== 1'b0 || freeze !== 1'b0 || retry_count !== 2'd0) $display("FAIL escalate_reset got=%h want=%h", got(), want()); else passed++;
  endtask

  task automatic test_critical();
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h88, 1);
    cyc(0, 1, 1, 1, 32'h8C, 1);
    checks++;
    if (!(halted === 1'b1 && freeze === 1'b1 && flush === 1'b0 && pc_restore_valid === 1'b0 && pc_restore === 32'h88))
      $display("FAIL critical_halt got=%h want halted, pc 88", got());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 32'h200 + 32'(i * 4), 1);
      checks++;
      if (got() !== want() || flush !== 1'b0 || pc_restore_valid !== 1'b0) $display("FAIL critical_hold%0d got=%h want=%h", i, got(), want()); else passed++;
    end
  endtask

  task automatic test_clean_window();
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h200, 1);
    cyc(0, 1, 0, 1, 32'hDEAD0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got() !== want() || pc_restore !== 32'h200) $display("FAIL window_ckpt%0d got=%h want pc 200", i, got()); else passed++;
      cyc(0, 0, 0, 0, 0, 1);
    end
    for (int i = 0; i < WIN; i++) begin
      checks++;
      if (got() !== want() || retry_count !== 2'd1) $display("FAIL window_hold%0d got=%h want retry 1", i, got()); else passed++;
      cyc(0, 0, 0, 1, 32'h1000 + 32'(i * 4), 1);
    end
    checks++;
    if (retry_count !== 2'd0 || pc_restore !== 32'h1000 + 32'((WIN - 1) * 4)) $display("FAIL window_clear got retry=%0d pc=%h want 0", retry_count, pc_restore); else passed++;
  endtask

  task automatic test_drain_wait();
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (halted !== 1'b0 || freeze !== 1'b1) $display("FAIL drain_16th got halted=%b freeze=%b want 0/1", halted, freeze); else passed++;
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (halted !== WD || freeze !== 1'b1 || flush !== 1'b0) $display("FAIL drain_timeout got halted=%b want %b", halted, WD); else passed++;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      checks++;
      if (got() !== want()) $display("FAIL drain_release%0d got=%h want=%h", i, got(), want()); else passed++;
    end
  endtask

  task automatic test_reset_in_flush();
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h300, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (flush !== 1'b1) $display("FAIL rst_flush_reach got flush=%b want 1", flush); else passed++;
    cyc(1, 1, 0, 1, 32'h400, 1);
    checks++;
    if ({freeze, flush, pc_restore_valid, halted, retry_count} !== 6'b0 || pc_restore !== 32'h0)
      $display("FAIL rst_flush_values got=%h want=%h", got(), 38'h0);
    else passed++;
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      bit fv = ($urandom % 10) == 0;
      cyc(($urandom % 150) == 0, fv, fv && ($urandom % 6) == 0, 1'($urandom), {$urandom_range(0, 32'h3FFF), 2'b00}, ($urandom % 4) != 0);
      checks++;
      if (got() !== want()) $display("FAIL random%0d got=%h want=%h", i, got(), want()); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_recovery();
    test_escalation();
    test_critical();
    test_clean_window();
    test_drain_wait();
    test_reset_in_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/recovery_sequencer.md
# recovery_sequencer

Sequencing controller for the CPU fault-recovery path. Keeps a checkpoint PC of the last cleanly committed instruction and, on a fault, steps the core through freeze, pipeline drain, flush and PC restore. It bounds repeated retries and escalates to a sticky halt. It sits between the fault classifier outputs and the core's PC/pipeline control, and drives the freeze/flush/restore strobes the safe-control path consumes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, reset value of the checkpoint and of pc_restore
- MAX_RETRY, 3, minor-fault recoveries allowed before escalation to HALT (≥1)
- RETRY_WINDOW, 64, consecutive clean commits that clear the retry count (≥1)
- DRAIN_TIMEOUT, 16, cycles allowed in DRAIN before watchdog escalation (macro-dependent)

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- fault_valid  input  1  fault reported this cycle
- fault_critical  input  1  qualifies fault_valid as critical (ignored when fault_valid=0)
- commit_valid  input  1  an instruction retired cleanly this cycle
- commit_pc  input  32  PC of the retiring instruction
- pipe_empty  input  1  no instructions in flight
- freeze  output  1  stall PC/regfile/memory writes
- flush  output  1  one-cycle pipeline flush strobe
- pc_restore_valid  output  1  one-cycle strobe: load pc_restore into PC
- pc_restore  output  32  checkpoint PC
- retry_count  output  $clog2(MAX_RETRY+1)  recoveries since last clean window
- halted  output  1  sticky unrecoverable state

## Operation
- States: RUN, DRAIN, FLUSH, RESTORE, HALT.
- All outputs are decoded from registered state. There is no combinational path from any input to any output.
- Output decode per state:
  - RUN: all strobes 0.
  - DRAIN: freeze=1.
  - FLUSH: freeze=1, flush=1.
  - RESTORE: freeze=1, pc_restore_valid=1.
  - HALT: freeze=1, halted=1.
- RUN, no fault:
  - commit_valid loads checkpoint ← commit_pc.
  - The clean counter increments and saturates at RETRY_WINDOW.
  - When it reaches RETRY_WINDOW, retry_count clears to 0.
- RUN with fault_valid:
  - fault_critical=1 or retry_count==MAX_RETRY → HALT.
  - Otherwise → DRAIN.
  - The clean counter clears. A commit_valid in the same cycle is discarded; the checkpoint is not updated.
- DRAIN: → FLUSH on pipe_empty. No checkpoint updates from DRAIN through RESTORE.
- FLUSH: unconditional → RESTORE.
- RESTORE: retry_count increments, saturating at MAX_RETRY. → RUN.
- Fault during DRAIN/FLUSH/RESTORE: critical → HALT; minor is ignored, since the recovery already in progress covers it.
- HALT: absorbing. Only reset exits. Inputs are ignored.
- pc_restore always reflects the checkpoint register.

## Timing
- Reset values:
  - state=RUN, checkpoint=pc_restore=RESET_PC
  - freeze=flush=pc_restore_valid=halted=0
  - retry_count=0, clean and watchdog counters=0
- Reset mid-recovery returns to RUN on the next edge, overriding all inputs.
- Fault sampled at edge N → freeze=1 from cycle N+1.
- Minimum recovery, with pipe_empty already high: DRAIN N+1, FLUSH N+2, RESTORE N+3, RUN N+4. This gives exactly 3 freeze cycles.
- flush and pc_restore_valid are each high for exactly one cycle per recovery.
- Checkpoint update latency is 1 cycle; a restore sees every commit accepted before the fault cycle.

## Configuration
- RECOVERY_WATCHDOG_EN defined:
  - The drain watchdog counts cycles in DRAIN, clearing on entry.
  - Reaching DRAIN_TIMEOUT without pipe_empty → HALT.
- Not defined:
  - There is no watchdog logic; DRAIN waits indefinitely for pipe_empty.
  - DRAIN_TIMEOUT is unused.

## Structure
- recovery_pkg holds:
  - the state enum with its fixed encoding: RUN=0, DRAIN=1, FLUSH=2, RESTORE=3, HALT=4
  - default parameter constants
- Sub-module drain_watchdog is instantiated only under RECOVERY_WATCHDOG_EN:
  - inputs: clk, reset, start, active
  - output: expired
- The checkpoint register, clean counter and FSM stay in the top module.

## Test plan
- Commits at PCs 0x100, 0x104, then a minor fault with pipe_empty=1 → freeze 3 cycles, one flush pulse, pc_restore_valid with pc_restore=0x104, retry_count=1.
- Four minor faults with MAX_RETRY=3 and no clean window in between → the first three recover; the fourth goes to HALT (halted=1, freeze=1) and stays there until reset.
- fault_valid=1 with fault_critical=1 in RUN → HALT next cycle, with no flush or restore pulse.
- Minor fault, then 64 clean commits → retry_count returns to 0; a commit coincident with the fault does not update the checkpoint.
- With RECOVERY_WATCHDOG_EN: fault with pipe_empty held at 0 → HALT after 16 DRAIN cycles. Without the macro: the block stays in DRAIN until pipe_empty rises, then recovers normally.
- Reset asserted in FLUSH → next cycle all outputs are at reset values and pc_restore=RESET_PC.
